// File: rtl/vga_frame_monitor.sv
// Passive VGA timing/content monitor: locks to vs, checks line/frame timing and
// reports a per-frame active-pixel count and additive checksum.
module vga_frame_monitor #(
    parameter int   COLOR_W    = 4,
    parameter int   H_TOTAL    = 1344,
    parameter int   H_SYNC     = 136,
    parameter int   H_BACK     = 160,
    parameter int   H_ACTIVE   = 1024,
    parameter int   V_TOTAL    = 806,
    parameter int   V_SYNC     = 6,
    parameter int   V_BACK     = 29,
    parameter int   V_ACTIVE   = 768,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   NUM_FRAMES = 2,
    parameter int   SUM_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hs,
    input  logic               vs,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic               frame_valid,
    output logic [15:0]        frame_cnt,
    output logic [SUM_W-1:0]   frame_sum,
    output logic [SUM_W-1:0]   frame_pix,
    output logic               err_hline,
    output logic               err_hsync,
    output logic               err_vframe,
    output logic               err_vsync,
    output logic               err_blank,
    output logic               done
);
    localparam int          PIX_W    = 3 * COLOR_W;
    localparam int          H_ACT_LO = H_SYNC + H_BACK;
    localparam int          H_ACT_HI = H_ACT_LO + H_ACTIVE;
    localparam int          V_ACT_LO = V_SYNC + V_BACK;
    localparam int          V_ACT_HI = V_ACT_LO + V_ACTIVE;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {ACQ, LOCK, DONE} state_t;
    state_t state, state_next;

    logic             hs_q, vs_q, hs_seen;
    logic [15:0]      h_cnt, v_cnt;
    logic [SUM_W-1:0] sum, pix;

    logic             hs_ae, hs_de, vs_ae, vs_de;
    logic [15:0]      h_pos, h_next, v_pos;
    logic             active, last_frame;
    logic [PIX_W-1:0] pixel;
    logic [SUM_W-1:0] sum_next, pix_next;

    // h_pos/v_pos are the positions of the current cycle: an assert edge
    // restarts the line at 0, and a new line bumps the line index at once.
    always_comb begin
        pixel  = {r, g, b};
        hs_ae  = (hs == HS_POL) && (hs_q != HS_POL);
        hs_de  = (hs != HS_POL) && (hs_q == HS_POL);
        vs_ae  = (vs == VS_POL) && (vs_q != VS_POL);
        vs_de  = (vs != VS_POL) && (vs_q == VS_POL);
        h_pos  = hs_ae ? 16'd0 : h_cnt;
        h_next = (h_pos == CNT_MAX) ? CNT_MAX : h_pos + 16'd1;
        if (vs_ae)
            v_pos = 16'd0;
        else if (hs_ae && v_cnt != CNT_MAX)
            v_pos = v_cnt + 16'd1;
        else
            v_pos = v_cnt;
        active = hs_seen
              && int'(h_pos) >= H_ACT_LO && int'(h_pos) < H_ACT_HI
              && int'(v_pos) >= V_ACT_LO && int'(v_pos) < V_ACT_HI;
        sum_next   = sum + (active ? SUM_W'(pixel) : '0);
        pix_next   = pix + (active ? SUM_W'(1) : '0);
        last_frame = (NUM_FRAMES != 0) && (int'(frame_cnt) + 1 == NUM_FRAMES);
    end

    always_comb begin
        state_next = state;
        case (state)
            ACQ:     if (vs_ae) state_next = LOCK;
            LOCK:    if (vs_ae && last_frame) state_next = DONE;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ACQ;
            hs_q        <= HS_POL;
            vs_q        <= VS_POL;
            hs_seen     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            sum         <= '0;
            pix         <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            frame_sum   <= '0;
            frame_pix   <= '0;
            err_hline   <= 1'b0;
            err_hsync   <= 1'b0;
            err_vframe  <= 1'b0;
            err_vsync   <= 1'b0;
            err_blank   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            hs_q        <= hs;
            vs_q        <= vs;
            frame_valid <= 1'b0;
            case (state)
                ACQ: begin
                    if (vs_ae) begin
                        h_cnt   <= '0;
                        v_cnt   <= '0;
                        hs_seen <= 1'b0;
                        sum     <= '0;
                        pix     <= '0;
                    end
                end
                LOCK: begin
                    h_cnt <= h_next;
                    v_cnt <= v_pos;
                    sum   <= sum_next;
                    pix   <= pix_next;
                    // h_cnt here still holds the previous cycle's position + 1
                    if (hs_ae) begin
                        if (hs_seen && int'(h_cnt) != H_TOTAL) err_hline <= 1'b1;
                        hs_seen <= 1'b1;
                    end
                    if (hs_de && hs_seen && int'(h_pos) != H_SYNC) err_hsync <= 1'b1;
                    if (vs_de && int'(v_pos) != V_SYNC) err_vsync <= 1'b1;
                    if (!active && pixel != '0) err_blank <= 1'b1;
                    if (vs_ae) begin
                        if (int'(v_cnt) != V_TOTAL - 1) err_vframe <= 1'b1;
                        frame_sum   <= sum_next;
                        frame_pix   <= pix_next;
                        frame_valid <= 1'b1;
                        frame_cnt   <= frame_cnt + 16'd1;
                        sum         <= '0;
                        pix         <= '0;
                        if (last_frame) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: reduced-size timings, random pixel content and a
// coordinate-based reference model of the expected per-frame results.
module tb_vga_frame_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hs_drv = 1'b0, vs_drv = 1'b0;
    logic [3:0] r = '0, g = '0, b = '0;
    logic       hs_b, vs_b;
    assign hs_b = ~hs_drv;
    assign vs_b = ~vs_drv;

    logic        fv_a, fv_b, hl_a, hl_b, hsy_a, hsy_b, vf_a, vf_b, vsy_a, vsy_b, bl_a, bl_b, done_a, done_b;
    logic [15:0] fc_a, fc_b;
    logic [31:0] fs_a, fs_b, fp_a, fp_b;

    vga_frame_monitor #(.COLOR_W(4), .H_TOTAL(16), .H_SYNC(3), .H_BACK(3), .H_ACTIVE(8),
        .V_TOTAL(12), .V_SYNC(2), .V_BACK(2), .V_ACTIVE(6), .HS_POL(1'b1), .VS_POL(1'b1),
        .NUM_FRAMES(2), .SUM_W(32)) dut_a (
        .clk(clk), .rst(rst), .hs(hs_drv), .vs(vs_drv), .r(r), .g(g), .b(b),
        .frame_valid(fv_a), .frame_cnt(fc_a), .frame_sum(fs_a), .frame_pix(fp_a),
        .err_hline(hl_a), .err_hsync(hsy_a), .err_vframe(vf_a), .err_vsync(vsy_a),
        .err_blank(bl_a), .done(done_a));

    vga_frame_monitor #(.COLOR_W(4), .H_TOTAL(10), .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4),
        .V_TOTAL(8), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .HS_POL(1'b0), .VS_POL(1'b0),
        .NUM_FRAMES(0), .SUM_W(32)) dut_b (
        .clk(clk), .rst(rst), .hs(hs_b), .vs(vs_b), .r(r), .g(g), .b(b),
        .frame_valid(fv_b), .frame_cnt(fc_b), .frame_sum(fs_b), .frame_pix(fp_b),
        .err_hline(hl_b), .err_hsync(hsy_b), .err_vframe(vf_b), .err_vsync(vsy_b),
        .err_blank(bl_b), .done(done_b));

    always #5 clk = ~clk;

    typedef struct { int ht, hsw, hb, ha, vt, vsw, vb, va; } tcfg_t;
    typedef struct { longint sum; longint pix; longint cyc; } rep_t;
    typedef struct {
        string      name;
        int         f0_lines, f0_vsw, short_line, wide_line, blank_line;
        logic [4:0] exp_err;  // {hline, hsync, vframe, vsync, blank}
    } scen_t;

    localparam tcfg_t CA = '{16, 3, 3, 8, 12, 2, 2, 6};
    localparam tcfg_t CB = '{10, 2, 2, 4, 8, 1, 1, 4};

    longint      cyc = 0, drive_cyc = 0;
    logic [31:0] fsum [8];
    logic [31:0] fpix [8];
    longint      fstart [8];
    logic [11:0] ramp_cnt = '0;
    rep_t        rep_a[$], rep_b[$];
    int          n_chk = 0, n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fv_a) rep_a.push_back('{longint'(fs_a), longint'(fp_a), cyc});
        if (fv_b) rep_b.push_back('{longint'(fs_b), longint'(fp_b), cyc});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic drive(input logic h, input logic v, input logic [11:0] px, input logic rst_pulse);
        @(negedge clk);
        hs_drv = h;
        vs_drv = v;
        r = px[11:8];
        g = px[7:4];
        b = px[3:0];
        rst = !rst_pulse;
        drive_cyc = cyc;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 12'h0, 1'b1);
        drive(1'b0, 1'b0, 12'h0, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 12'h0, 1'b0);
    endtask

    // Reference: a pixel counts when its generated (line, x) lies in the nominal active window.
    task automatic send_frame(input tcfg_t c, input int lines, input int vsw, input int short_line,
                              input int wide_line, input int blank_line, input int fidx, input bit ramp);
        logic [31:0] s, p;
        logic [11:0] px;
        int          len, hw;
        bit          act;
        s = '0;
        p = '0;
        for (int l = 0; l < lines; l++) begin
            len = (l == short_line) ? c.ht - 1 : c.ht;
            hw  = (l == wide_line) ? c.hsw + 1 : c.hsw;
            for (int x = 0; x < len; x++) begin
                act = (x >= c.hsw + c.hb) && (x < c.hsw + c.hb + c.ha)
                   && (l >= c.vsw + c.vb) && (l < c.vsw + c.vb + c.va);
                px = '0;
                if (act) begin
                    px = ramp ? ramp_cnt : 12'($urandom);
                    ramp_cnt = ramp_cnt + 12'd1;
                    s = s + 32'(px);
                    p = p + 32'd1;
                end
                if (l == blank_line && x == 0) px = 12'h100;
                drive(x < hw, l < vsw, px, 1'b0);
                if (l == 0 && x == 0) fstart[fidx] = drive_cyc;
            end
        end
        fsum[fidx] = s;
        fpix[fidx] = p;
    endtask

    task automatic chk_rep_a(input string nm, input int k, input int f);
        rep_t e;
        e = '{-1, -1, -1};
        if (k < rep_a.size()) e = rep_a[k];
        chk($sformatf("%s_sum%0d", nm, k), e.sum, 64'(fsum[f]));
        chk($sformatf("%s_pix%0d", nm, k), e.pix, 64'(fpix[f]));
        chk($sformatf("%s_lat%0d", nm, k), e.cyc, fstart[f + 1] + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl [6];
        rep_t  e;
        tbl[0] = '{"ideal",  12, 2, -1, -1, -1, 5'b00000};
        tbl[1] = '{"hline",  12, 2,  4, -1, -1, 5'b10000};
        tbl[2] = '{"hsync",  12, 2, -1,  7, -1, 5'b01000};
        tbl[3] = '{"vframe", 11, 2, -1, -1, -1, 5'b00100};
        tbl[4] = '{"vsync",  12, 1, -1, -1, -1, 5'b00010};
        tbl[5] = '{"blank",  12, 2, -1, -1,  5, 5'b00001};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            chk({tbl[i].name, "_rst_ctl"}, {fv_a, fc_a, hl_a, hsy_a, vf_a, vsy_a, bl_a, done_a}, '0);
            chk({tbl[i].name, "_rst_sum"}, fs_a, '0);
            chk({tbl[i].name, "_rst_pix"}, fp_a, '0);
            rep_a.delete();
            send_frame(CA, tbl[i].f0_lines, tbl[i].f0_vsw, tbl[i].short_line,
                       tbl[i].wide_line, tbl[i].blank_line, 0, 1'b0);
            send_frame(CA, CA.vt, CA.vsw, -1, -1, -1, 1, 1'b0);
            send_frame(CA, CA.vt, CA.vsw, -1, -1, -1, 2, 1'b0);
            send_frame(CA, 1, CA.vsw, -1, -1, -1, 3, 1'b0);
            repeat (3) @(negedge clk);
            chk({tbl[i].name, "_err_hline"},  hl_a,  tbl[i].exp_err[4]);
            chk({tbl[i].name, "_err_hsync"},  hsy_a, tbl[i].exp_err[3]);
            chk({tbl[i].name, "_err_vframe"}, vf_a,  tbl[i].exp_err[2]);
            chk({tbl[i].name, "_err_vsync"},  vsy_a, tbl[i].exp_err[1]);
            chk({tbl[i].name, "_err_blank"},  bl_a,  tbl[i].exp_err[0]);
            chk({tbl[i].name, "_nvalid"}, rep_a.size(), 2);
            chk({tbl[i].name, "_frame_cnt"}, fc_a, 2);
            chk({tbl[i].name, "_done"}, done_a, 1);
            chk({tbl[i].name, "_held_sum"}, fs_a, 64'(fsum[1]));
            chk_rep_a(tbl[i].name, 0, 0);
            chk_rep_a(tbl[i].name, 1, 1);
        end

        // Reset in the middle of a frame discards it; next vs only re-locks.
        do_reset();
        rep_a.delete();
        send_frame(CA, CA.vt, CA.vsw, -1, -1, -1, 0, 1'b0);
        send_frame(CA, 5, CA.vsw, -1, -1, -1, 1, 1'b0);
        drive(1'b1, 1'b0, 12'h0, 1'b1);
        drive(1'b1, 1'b0, 12'h0, 1'b0);
        chk("midrst_ctl", {fv_a, fc_a, hl_a, hsy_a, vf_a, vsy_a, bl_a, done_a}, '0);
        chk("midrst_sum", fs_a, '0);
        chk("midrst_pix", fp_a, '0);
        rep_a.delete();
        repeat (100) drive(1'b0, 1'b0, 12'h0, 1'b0);
        send_frame(CA, CA.vt, CA.vsw, -1, -1, -1, 2, 1'b0);
        chk("midrst_no_early_valid", rep_a.size(), 0);
        send_frame(CA, CA.vt, CA.vsw, -1, -1, -1, 3, 1'b0);
        send_frame(CA, 1, CA.vsw, -1, -1, -1, 4, 1'b0);
        repeat (3) @(negedge clk);
        e = '{-1, -1, -1};
        if (rep_a.size() > 0) e = rep_a[0];
        chk("midrst_nvalid", rep_a.size(), 2);
        chk("midrst_sum0", e.sum, 64'(fsum[2]));
        chk("midrst_lat0", e.cyc, fstart[3] + 1);
        chk("midrst_done", done_a, 1);

        // Active-low syncs, free-running, ramp pixels.
        do_reset();
        rep_b.delete();
        ramp_cnt = '0;
        for (int f = 0; f < 4; f++) send_frame(CB, CB.vt, CB.vsw, -1, -1, -1, f, 1'b1);
        send_frame(CB, 1, CB.vsw, -1, -1, -1, 4, 1'b1);
        repeat (3) @(negedge clk);
        chk("small_nvalid", rep_b.size(), 4);
        for (int k = 0; k < 4; k++) begin
            e = '{-1, -1, -1};
            if (k < rep_b.size()) e = rep_b[k];
            chk($sformatf("small_pix%0d", k), e.pix, 16);
            chk($sformatf("small_sum%0d", k), e.sum, 64'(fsum[k]));
            chk($sformatf("small_lat%0d", k), e.cyc, fstart[k + 1] + 1);
        end
        chk("small_done", done_b, 0);
        chk("small_frame_cnt", fc_b, 4);
        chk("small_errs", {hl_b, hsy_b, vf_b, vsy_b, bl_b}, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
